// File: rtl/cdc_count_monitor.sv
// cdc_count_monitor
//   Destination-domain consumer of a recovered gray->binary count. It measures
//   the modulo-2^K step between successive distinct samples and accumulates
//   accepted steps into a saturating total. It also flags two conditions:
//   a stall, when the count stays frozen too long, and corruption, when one
//   step is larger than a synchronised gray advance can legally produce.
//
//   Optional feature: define CNT_MON_MAXD_EN to build the max_delta tracker.
//   Without it, max_delta is tied to zero.
//
// Ports
//   clk       destination-domain clock
//   rst       synchronous active-high reset (priority over clr)
//   en        monitor enable; 0 holds all state, valid drops
//   clr       synchronous clear, same effect as rst
//   cnt_in    K-bit binary count from the CDC path
//   valid     one-cycle pulse when a change was observed
//   delta     last nonzero step (cnt_in - prev) mod 2^K
//   total     saturating W-bit sum of accepted steps
//   stall     count frozen for >= STALL_CYC enabled cycles
//   err       sticky corruption flag
//   state     00 INIT, 01 RUN, 10 STALL, 11 ERR
//   max_delta largest accepted step since clear (0 when feature not built)
module cdc_count_monitor #(
  parameter int K         = 8,
  parameter int W         = 32,
  parameter int MAX_STEP  = 4,
  parameter int STALL_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [K-1:0] cnt_in,
  output logic         valid,
  output logic [K-1:0] delta,
  output logic [W-1:0] total,
  output logic         stall,
  output logic         err,
  output logic [1:0]   state,
  output logic [K-1:0] max_delta
);

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_ERR   = 2'b11
  } state_e;

  // The idle counter is 0 on the capture cycle. It stalls when it reaches
  // STALL_CYC-1, so STALL_CYC enabled cycles with the same value assert stall.
  localparam int IW = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(STALL_CYC - 1);
  localparam logic [K-1:0]  MAX_D     = K'(MAX_STEP);

  state_e        state_q, state_d;
  logic [K-1:0]  prev_q, prev_d;
  logic [K-1:0]  delta_q, delta_d;
  logic [W-1:0]  total_q, total_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          valid_q, valid_d;
  logic          stall_q, stall_d;
  logic          err_q, err_d;
  logic          acc;    // an accepted (legal, nonzero) step this cycle

  logic [K-1:0]  step;
  logic [W:0]    sum;

  assign step = cnt_in - prev_q;   // natural modulo-2^K wrap
  assign sum  = {1'b0, total_q} + {{(W+1-K){1'b0}}, step};

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    delta_d = delta_q;
    total_d = total_q;
    idle_d  = idle_q;
    valid_d = 1'b0;
    stall_d = stall_q;
    err_d   = err_q;
    acc     = 1'b0;
    if (en) begin
      unique case (state_q)
        S_INIT: begin
          prev_d  = cnt_in;
          idle_d  = '0;
          state_d = S_RUN;
        end
        S_RUN, S_STALL: begin
          if (step == '0) begin
            // While in STALL the counter stays at IDLE_LAST (it saturates).
            if (state_q == S_RUN) begin
              idle_d = idle_q + 1'b1;
              if (idle_d == IDLE_LAST) begin
                stall_d = 1'b1;
                state_d = S_STALL;
              end
            end
          end else if (step <= MAX_D) begin
            acc     = 1'b1;
            valid_d = 1'b1;
            delta_d = step;
            prev_d  = cnt_in;
            idle_d  = '0;
            total_d = sum[W] ? '1 : sum[W-1:0];
            stall_d = 1'b0;
            state_d = S_RUN;
          end else begin
            // Corruption: report the step but do not accumulate it.
            valid_d = 1'b1;
            delta_d = step;
            prev_d  = cnt_in;
            err_d   = 1'b1;
            stall_d = 1'b0;
            state_d = S_ERR;
          end
        end
        S_ERR: ;
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= S_INIT;
      prev_q  <= '0;
      delta_q <= '0;
      total_q <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      delta_q <= delta_d;
      total_q <= total_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

`ifdef CNT_MON_MAXD_EN
  logic [K-1:0] maxd_q;
  always_ff @(posedge clk) begin
    if (rst || clr)                    maxd_q <= '0;
    else if (acc && (step > maxd_q))   maxd_q <= step;
  end
  assign max_delta = maxd_q;
`else
  logic unused_acc;
  assign unused_acc = acc;
  assign max_delta  = '0;
`endif

  assign valid = valid_q;
  assign delta = delta_q;
  assign total = total_q;
  assign stall = stall_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_cdc_count_monitor.sv
// Randomised plus directed bench for cdc_count_monitor (K=8, W=8,
// MAX_STEP=4, STALL_CYC=16). An abstract reference model tracks the last
// captured value, how many enabled cycles it has been held, and whether the
// monitor has started or hit corruption. After each edge the model is
// compared with every DUT output.
module tb_cdc_count_monitor;
  localparam int K = 8, W = 8, MAX_STEP = 4, STALL_CYC = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [K-1:0] cnt_in = '0;
  logic         valid, stall, err;
  logic [K-1:0] delta, max_delta;
  logic [W-1:0] total;
  logic [1:0]   state;

  cdc_count_monitor #(.K(K), .W(W), .MAX_STEP(MAX_STEP), .STALL_CYC(STALL_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt_in(cnt_in),
    .valid(valid), .delta(delta), .total(total), .stall(stall),
    .err(err), .state(state), .max_delta(max_delta)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model state
  bit started, m_err, m_valid, m_stall;
  int m_prev, m_held, m_total, m_delta, m_maxd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!started)    return 2'b00;
    else if (m_err)  return 2'b11;
    else if (m_stall) return 2'b10;
    else             return 2'b01;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit e, input int x);
    int d;
    if (r || c) begin
      started = 0; m_err = 0; m_valid = 0; m_stall = 0;
      m_prev = 0; m_held = 0; m_total = 0; m_delta = 0; m_maxd = 0;
    end else if (!e || m_err) begin
      m_valid = 0;
    end else if (!started) begin
      started = 1; m_prev = x; m_held = 1; m_valid = 0;
    end else begin
      d = (x - m_prev + 256) % 256;
      if (d == 0) begin
        m_valid = 0;
        if (m_held < STALL_CYC) m_held++;
        if (m_held >= STALL_CYC) m_stall = 1;
      end else if (d <= MAX_STEP) begin
        m_valid = 1; m_delta = d; m_prev = x; m_held = 1; m_stall = 0;
        m_total = (m_total + d > 255) ? 255 : m_total + d;
        if (d > m_maxd) m_maxd = d;
      end else begin
        m_valid = 1; m_delta = d; m_prev = x; m_err = 1; m_stall = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", valid, m_valid);
    chk("delta", delta, m_delta);
    chk("total", total, m_total);
    chk("stall", stall, m_stall);
    chk("err",   err,   m_err);
    chk("state", state, m_state());
`ifdef CNT_MON_MAXD_EN
    chk("max_delta", max_delta, m_maxd);
`else
    chk("max_delta", max_delta, 0);
`endif
  endtask

  task automatic tick(input bit r, input bit c, input bit e, input logic [7:0] x);
    @(negedge clk);
    rst = r; clr = c; en = e; cnt_in = x;
    @(posedge clk);
    model_step(r, c, e, int'(x));
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] x;
    bit r, c, e;
    int hold_left;
    started = 0; m_err = 0; m_valid = 0; m_stall = 0;
    m_prev = 0; m_held = 0; m_total = 0; m_delta = 0; m_maxd = 0;

    // 1: reset, then INIT -> RUN on the first enabled cycle
    tick(1, 0, 0, 8'h05);
    chk("reset_state", state, 2'b00);
    tick(0, 0, 1, 8'h05);
    chk("init_to_run", state, 2'b01);
    tick(0, 0, 1, 8'h05);

    // 2: +1 changes every 3 cycles
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 8'h06);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 8'h07);
    chk("total_two", total, 8'd2);

    // 3: wrap step 0xFE -> 0x01 = 3
    tick(0, 1, 1, 8'hFE);
    tick(0, 0, 1, 8'hFE);
    tick(0, 0, 1, 8'h01);
    chk("wrap_delta", delta, 8'd3);

    // 4: corruption and sticky error until clr
    tick(0, 1, 1, 8'h10);
    tick(0, 0, 1, 8'h10);
    tick(0, 0, 1, 8'h20);
    chk("err_delta", delta, 8'h10);
    tick(0, 0, 1, 8'h21);
    tick(0, 0, 1, 8'h22);
    tick(0, 1, 1, 8'h23);
    chk("clr_err", err, 1'b0);

    // 5: hold with en gaps; stall, then recover on +1
    tick(0, 0, 1, 8'h30);
    for (int i = 0; i < 24; i++) tick(0, 0, (i % 3) != 1, 8'h30);
    chk("stall_set", stall, 1'b1);
    tick(0, 0, 1, 8'h31);
    chk("stall_clr", stall, 1'b0);

    // 6: saturate total, then clr with a simultaneous change
    tick(0, 1, 1, 8'h00);
    x = 8'h00;
    tick(0, 0, 1, x);
    for (int i = 0; i < 63; i++) begin x = x + 8'd4; tick(0, 0, 1, x); end
    x = x + 8'd1; tick(0, 0, 1, x);
    chk("total_fd", total, 8'hFD);
    x = x + 8'd4; tick(0, 0, 1, x);
    chk("total_sat", total, 8'hFF);
    x = x + 8'd1; tick(0, 1, 1, x);
    chk("clr_total", total, 8'h00);

    // Randomised traffic
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 7) != 0);
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 39) == 0) hold_left = $urandom_range(10, 25);
      else begin
        case ($urandom_range(0, 59))
          0:       x = 8'($urandom);
          1,2,3,4,5,6,7,8,9,10,11,12: ;
          default: x = x + 8'($urandom_range(1, MAX_STEP));
        endcase
      end
      tick(r, c, e, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
